seg7_scroll_mux: RTL and testbench
==================================

# seg7_scroll_mux

Time-multiplexed, parametrised driver for a row of common-anode/cathode 7-segment digits. It scrolls a fixed text message across the row. Sits between the top-level board pins and the glyph decoder: scans one digit at a time and advances the visible window through a ring of message glyphs plus a blank gap. Scroll direction and enable are selectable at run time.

## Interface
- NUM_DIGITS, 4: physical digits; digit 0 is leftmost and is driven by an[0].
- MSG_LEN, 7: message glyph count.
- MSG, {D_CODE…}: packed MSG_LEN×4-bit glyph codes, entry 0 in bits [3:0]. Default spells C,L,A,U,D,I,A.
- SCAN_DIV, 1000: clk cycles each digit is lit; must be ≥2.
- SCROLL_FRAMES, 50: full scan frames per scroll step; must be ≥1.
- AN_ACTIVE_LOW, 1: anode polarity.
- clk, input, 1: sole clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: display enable.
- scroll_en, input, 1: allow scroll steps.
- dir, input, 1: 0 = scroll left (pos+1), 1 = scroll right (pos−1).
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-high.
- an, output, NUM_DIGITS: one-hot digit select, polarity per AN_ACTIVE_LOW.
- pos, output, clog2(RING): current window start index.
- wrap, output, 1: one-cycle pulse when pos wraps in either direction.

## Operation
- Ring: RING = MSG_LEN + NUM_DIGITS entries. Entries 0..MSG_LEN−1 come from MSG. The rest are BLANK.
- Digit k shows ring[(pos + k) mod RING], decoded to segments by the glyph sub-module.
- Scan counter runs 0..SCAN_DIV−1. At its terminal count, the digit index advances 0..NUM_DIGITS−1 and wraps to 0. Each wrap ends a frame.
- Frame counter runs 0..SCROLL_FRAMES−1. A frame end at the terminal count is a scroll step.
  - A step occurs only if scroll_en=1. It updates pos by +1 or −1 mod RING per dir.
  - wrap is asserted for the cycle after a step that crosses RING−1→0 or 0→RING−1.
  - With scroll_en=0, the frame counter still wraps and pos holds.
- en=0: all counters and pos hold; an is all-inactive; seg=0; wrap=0. Re-asserting en resumes at the held digit and scan count.
- dir and scroll_en are sampled only at the step edge. Changes mid-frame have no other effect.
- All arithmetic is modulo its range; no intermediate value exceeds clog2(max)+1 bits.

## Timing
- Reset values:
  - seg=7'b0000000
  - an all-inactive (4'b1111 when AN_ACTIVE_LOW)
  - pos=0, wrap=0
  - all counters 0
- Reset asserted mid-operation clears everything immediately (asynchronously).
- seg and an are registered. They reflect the digit index and pos with one cycle of latency and always change on the same edge: no ghosting cycle with mismatched seg/an.
- First edge after reset release: an selects digit 0 and seg shows ring[0].
- Step coincident with digit wrap: the new pos and digit 0 take effect together, so the whole next frame uses the new window.
- Digit period is exactly SCAN_DIV cycles. Frame period is NUM_DIGITS×SCAN_DIV. Step period is SCROLL_FRAMES frames.

## Structure
- Package seg7_pkg holds:
  - the 4-bit glyph code localparams: BLANK=0, C=1, L=2, A=3, U=4, D=5, I=6
  - each code's 7-bit segment pattern, e.g. C=7'b0111001, A=7'b1110111, L=7'b0111000, U=7'b0111110, D=7'b0111111, I=7'b0000110
  - a default MSG constant
- Sub-module seg7_glyph is purely combinational. It maps a glyph code to seg; undefined codes map to 0.
- The counters, ring indexing and output registers live in seg7_scroll_mux.

## Test plan
Parameters: NUM_DIGITS=4, SCAN_DIV=4, SCROLL_FRAMES=2, AN_ACTIVE_LOW=1, default MSG (RING=11).
- Reset hold → an=4'b1111, seg=0, pos=0. After release, first edge gives an=4'b1110, seg=7'b0111001 (C).
- Free run with scroll_en=0 → digits show C,L,A,U. Each is lit 4 cycles, frame is 16 cycles, pos stays 0.
- scroll_en=1, dir=0 → after 32 cycles pos=1 and the window reads L,A,U,D. At pos=7 the window is all blank (seg=0 for every digit).
- Continue left to pos=10 → window is blank,C,L,A. The next step gives pos=0 with a one-cycle wrap=1.
- From pos=0 set dir=1 → after the step pos=10 with wrap=1. Toggling dir mid-frame has no effect until the step edge.
- Drop en mid-digit for 5 cycles → next cycle an=4'b1111, seg=0. On re-enable, the same digit resumes with its remaining scan cycles intact. Asserting rst_n=0 mid-frame clears the outputs immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph codes, segment patterns and default message for
// the scrolling 7-segment driver.
//   glyph_t      - 4-bit glyph code
//   BLANK..I     - glyph code constants
//   SEG_*        - segment patterns {g,f,e,d,c,b,a}, active-high
//   DEFAULT_MSG  - "CLAUDIA", entry 0 in bits [3:0]
package seg7_pkg;

    typedef logic [3:0] glyph_t;

    localparam glyph_t BLANK = 4'd0;
    localparam glyph_t C     = 4'd1;
    localparam glyph_t L     = 4'd2;
    localparam glyph_t A     = 4'd3;
    localparam glyph_t U     = 4'd4;
    localparam glyph_t D     = 4'd5;
    localparam glyph_t I     = 4'd6;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_L     = 7'b0111000;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_U     = 7'b0111110;
    localparam logic [6:0] SEG_D     = 7'b0111111;
    localparam logic [6:0] SEG_I     = 7'b0000110;

    localparam int DEFAULT_MSG_LEN = 7;
    localparam logic [DEFAULT_MSG_LEN*4-1:0] DEFAULT_MSG = {A, I, D, U, A, L, C};

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational glyph-code to segment decoder.
//   code_i - glyph code
//   seg_o  - segments {g,f,e,d,c,b,a}, active-high; unknown codes are dark
module seg7_glyph
    import seg7_pkg::*;
(
    input  glyph_t     code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            C:       seg_o = SEG_C;
            L:       seg_o = SEG_L;
            A:       seg_o = SEG_A;
            U:       seg_o = SEG_U;
            D:       seg_o = SEG_D;
            I:       seg_o = SEG_I;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scroll_mux.sv
// seg7_scroll_mux: time-multiplexed scrolling driver for a row of 7-segment
// digits. The visible window walks a ring of MSG glyphs followed by
// NUM_DIGITS blanks.
//   clk, rst_n    - clock, asynchronous active-low reset
//   en            - display enable (0: everything holds, outputs dark)
//   scroll_en     - allow scroll steps (sampled at the step edge only)
//   dir           - 0: pos+1 (scroll left), 1: pos-1 (scroll right)
//   seg           - registered segments {g,f,e,d,c,b,a}, active-high
//   an            - registered one-hot digit select, polarity AN_ACTIVE_LOW
//   pos           - window start index into the ring
//   wrap          - one-cycle pulse after a step that wraps pos
module seg7_scroll_mux
    import seg7_pkg::*;
#(
    parameter int                       NUM_DIGITS    = 4,
    parameter int                       MSG_LEN       = DEFAULT_MSG_LEN,
    parameter logic [MSG_LEN*4-1:0]     MSG           = DEFAULT_MSG,
    parameter int                       SCAN_DIV      = 1000,
    parameter int                       SCROLL_FRAMES = 50,
    parameter bit                       AN_ACTIVE_LOW = 1'b1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          en,
    input  logic                                          scroll_en,
    input  logic                                          dir,
    output logic [6:0]                                    seg,
    output logic [NUM_DIGITS-1:0]                         an,
    output logic [$clog2(MSG_LEN+NUM_DIGITS)-1:0]         pos,
    output logic                                          wrap
);

    localparam int RING = MSG_LEN + NUM_DIGITS;
    localparam int PW   = $clog2(RING);
    localparam int SW   = $clog2(SCAN_DIV);
    localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW   = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [SW-1:0]         SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]         DIG_LAST   = DW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         FRAME_LAST = FW'(SCROLL_FRAMES - 1);
    localparam logic [PW-1:0]         POS_LAST   = PW'(RING - 1);
    localparam logic [PW:0]           RING_W     = (PW+1)'(RING);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [SW-1:0]         scan_q, scan_d;
    logic [DW-1:0]         dig_q, dig_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic                  wrap_q, wrap_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    glyph_t                ring [RING];
    logic [PW:0]           sum;
    logic [PW-1:0]         idx;
    logic                  scan_last, frame_end, step;

    // Message glyphs followed by the blank gap.
    always_comb begin
        for (int i = 0; i < RING; i++) begin
            ring[i] = (i < MSG_LEN) ? MSG[i*4 +: 4] : BLANK;
        end
    end

    // pos + digit is below 2*RING, so a single conditional subtract wraps it.
    always_comb begin
        sum = {1'b0, pos_q} + (PW+1)'(dig_q);
        idx = (sum >= RING_W) ? PW'(sum - RING_W) : PW'(sum);
    end

    seg7_glyph u_glyph (
        .code_i (ring[idx]),
        .seg_o  (seg_d)
    );

    always_comb begin
        scan_last = (scan_q == SCAN_LAST);
        frame_end = scan_last && (dig_q == DIG_LAST);
        step      = frame_end && (frame_q == FRAME_LAST) && scroll_en;

        scan_d  = scan_last ? '0 : scan_q + 1'b1;
        dig_d   = dig_q;
        if (scan_last) dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        frame_d = frame_q;
        if (frame_end) frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;

        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (step) begin
            if (!dir) begin
                pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                wrap_d = (pos_q == POS_LAST);
            end else begin
                pos_d  = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
                wrap_d = (pos_q == '0);
            end
        end

        an_d = NUM_DIGITS'(1) << dig_q;
        if (AN_ACTIVE_LOW) an_d = ~an_d;
    end

    // seg and an are loaded from the same pre-edge digit/pos so they always
    // switch together; a step at digit wrap lands with digit 0 on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q  <= '0;
            dig_q   <= '0;
            frame_q <= '0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= '0;
            an_q    <= AN_OFF;
        end else if (!en) begin
            wrap_q  <= 1'b0;
            seg_q   <= '0;
            an_q    <= AN_OFF;
        end else begin
            scan_q  <= scan_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_seg7_scroll_mux.sv
module tb_seg7_scroll_mux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       scroll_en = 1'b0;
    logic       dir = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] pos;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_scroll_mux #(
        .NUM_DIGITS    (4),
        .MSG_LEN       (7),
        .SCAN_DIV      (4),
        .SCROLL_FRAMES (2),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .scroll_en (scroll_en),
        .dir       (dir),
        .seg       (seg),
        .an        (an),
        .pos       (pos),
        .wrap      (wrap)
    );

    // Expected segments for ring entry r of "CLAUDIA" + 4 blanks.
    function automatic logic [6:0] exp_seg(input int r);
        case (r)
            0: return 7'b0111001;  // C
            1: return 7'b0111000;  // L
            2: return 7'b1110111;  // A
            3: return 7'b0111110;  // U
            4: return 7'b0111111;  // D
            5: return 7'b0000110;  // I
            6: return 7'b1110111;  // A
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int d);
        logic [3:0] v;
        v = 4'b1111;
        v[d] = 1'b0;
        return v;
    endfunction

    task automatic do_reset(input bit s, input bit dr);
        rst_n = 1'b0;
        en = 1'b1;
        scroll_en = s;
        dir = dr;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        scroll_en = 1'b0;
        dir = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", an); end
        total++; if (seg !== 7'b0) begin bad++; $display("FAIL reset_seg got=%b exp=0000000", seg); end
        total++; if (pos !== 4'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", pos); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        rst_n = 1'b1;
        edge_step();
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL first_an got=%b exp=1110", an); end
        total++; if (seg !== 7'b0111001) begin bad++; $display("FAIL first_seg got=%b exp=0111001", seg); end
    endtask

    task automatic test_freerun();
        int d;
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 48; k++) begin
            edge_step();
            d = ((k - 1) / 4) % 4;
            total++; if (an !== exp_an(d)) begin bad++; $display("FAIL freerun_an k=%0d got=%b exp=%b", k, an, exp_an(d)); end
            total++; if (seg !== exp_seg(d)) begin bad++; $display("FAIL freerun_seg k=%0d got=%b exp=%b", k, seg, exp_seg(d)); end
            total++; if (pos !== 4'd0) begin bad++; $display("FAIL freerun_pos k=%0d got=%0d exp=0", k, pos); end
        end
    endtask

    task automatic test_scroll_left();
        int d, pd, pn, nwrap;
        nwrap = 0;
        do_reset(1'b1, 1'b0);
        for (int k = 1; k <= 368; k++) begin
            edge_step();
            d  = ((k - 1) / 4) % 4;
            pd = ((k - 1) / 32) % 11;
            pn = (k / 32) % 11;
            if (wrap === 1'b1) nwrap++;
            total++; if (an !== exp_an(d)) begin bad++; $display("FAIL left_an k=%0d got=%b exp=%b", k, an, exp_an(d)); end
            total++; if (seg !== exp_seg((pd + d) % 11)) begin bad++; $display("FAIL left_seg k=%0d got=%b exp=%b", k, seg, exp_seg((pd + d) % 11)); end
            total++; if (pos !== 4'(pn)) begin bad++; $display("FAIL left_pos k=%0d got=%0d exp=%0d", k, pos, pn); end
            total++; if (wrap !== (k == 352)) begin bad++; $display("FAIL left_wrap k=%0d got=%b exp=%b", k, wrap, (k == 352)); end
        end
        total++; if (nwrap != 1) begin bad++; $display("FAIL left_wrap_count got=%0d exp=1", nwrap); end
    endtask

    task automatic test_scroll_right();
        int d, pd, pn;
        bit ew;
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            // dir toggles mid-frame; only its value at edges 32 and 64 counts
            if (k <= 10)      dir = 1'b1;
            else if (k <= 20) dir = 1'b0;
            else if (k <= 40) dir = 1'b1;
            else if (k <= 50) dir = 1'b0;
            else if (k <= 55) dir = 1'b1;
            else              dir = 1'b0;
            edge_step();
            d  = ((k - 1) / 4) % 4;
            pd = (k <= 32) ? 0 : (k <= 64) ? 10 : 0;
            pn = (k < 32) ? 0 : (k < 64) ? 10 : 0;
            ew = (k == 32) || (k == 64);
            total++; if (pos !== 4'(pn)) begin bad++; $display("FAIL right_pos k=%0d got=%0d exp=%0d", k, pos, pn); end
            total++; if (wrap !== ew) begin bad++; $display("FAIL right_wrap k=%0d got=%b exp=%b", k, wrap, ew); end
            total++; if (seg !== exp_seg((pd + d) % 11)) begin bad++; $display("FAIL right_seg k=%0d got=%b exp=%b", k, seg, exp_seg((pd + d) % 11)); end
        end
    endtask

    task automatic test_enable();
        int lit;
        lit = 0;
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            edge_step();
            if (an === 4'b1101) lit++;
        end
        en = 1'b0;
        for (int k = 7; k <= 11; k++) begin
            edge_step();
            total++; if (an !== 4'b1111) begin bad++; $display("FAIL en_off_an k=%0d got=%b exp=1111", k, an); end
            total++; if (seg !== 7'b0) begin bad++; $display("FAIL en_off_seg k=%0d got=%b exp=0000000", k, seg); end
            total++; if (wrap !== 1'b0) begin bad++; $display("FAIL en_off_wrap k=%0d got=%b exp=0", k, wrap); end
        end
        en = 1'b1;
        for (int k = 12; k <= 13; k++) begin
            edge_step();
            if (an === 4'b1101) lit++;
            total++; if (an !== 4'b1101) begin bad++; $display("FAIL en_resume_an k=%0d got=%b exp=1101", k, an); end
            total++; if (seg !== 7'b0111000) begin bad++; $display("FAIL en_resume_seg k=%0d got=%b exp=0111000", k, seg); end
        end
        edge_step();
        total++; if (an !== 4'b1011) begin bad++; $display("FAIL en_next_an got=%b exp=1011", an); end
        total++; if (seg !== 7'b1110111) begin bad++; $display("FAIL en_next_seg got=%b exp=1110111", seg); end
        total++; if (lit != 4) begin bad++; $display("FAIL en_lit_cycles got=%0d exp=4", lit); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) edge_step();
        total++; if (pos !== 4'd1) begin bad++; $display("FAIL mid_pre_pos got=%0d exp=1", pos); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL mid_rst_an got=%b exp=1111", an); end
        total++; if (seg !== 7'b0) begin bad++; $display("FAIL mid_rst_seg got=%b exp=0000000", seg); end
        total++; if (pos !== 4'd0) begin bad++; $display("FAIL mid_rst_pos got=%0d exp=0", pos); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL mid_rst_wrap got=%b exp=0", wrap); end
        @(negedge clk);
        rst_n = 1'b1;
        edge_step();
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL mid_restart_an got=%b exp=1110", an); end
        total++; if (seg !== 7'b0111001) begin bad++; $display("FAIL mid_restart_seg got=%b exp=0111001", seg); end
    endtask

    initial begin
        test_reset();
        test_freerun();
        test_scroll_left();
        test_scroll_right();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
